// File: rtl/systolic_feeder_pkg.sv
// systolic_feeder_pkg: shared FSM encoding and size helpers for the feeder
package systolic_feeder_pkg;

    typedef enum logic [1:0] {IDLE, CLEAR, FEED, FIN} state_t;

    function automatic int imax(int a, int b);
        return a > b ? a : b;
    endfunction

    function automatic int feed_len(int m, int n, int k);
        return n + imax(m, k) - 1;
    endfunction

endpackage

// File: rtl/systolic_feeder_buf.sv
// feeder_buf: R x C operand register buffer, single write port, full-matrix read
module feeder_buf
    import systolic_feeder_pkg::*;
#(
    parameter int R  = 5,
    parameter int C  = 3,
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [AW-1:0]       addr,
    input  logic [DW-1:0]       data,
    output logic [DW*R*C-1:0]   mem
);

    always_ff @(posedge clk or posedge rst)
        if (rst)
            mem <= '0;
        else if (wr_en && int'(addr) < R * C)
            mem[DW*addr +: DW] <= data;

endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: stages X/W operands and streams them diagonally skewed to the array
module systolic_feeder
    import systolic_feeder_pkg::*;
#(
    parameter int M          = 5,
    parameter int N          = 3,
    parameter int K          = 4,
    parameter int DATA_WIDTH = 32,
    localparam int AW        = $clog2(imax(M * N, N * K))
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic                    wr_sel,
    input  logic [AW-1:0]           wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    start,
    output logic                    busy,
    output logic                    arr_clr,
    output logic [DATA_WIDTH*M-1:0] X_out,
    output logic [DATA_WIDTH*K-1:0] W_out,
    output logic                    feed_valid,
    output logic                    done
);

    localparam int T  = feed_len(M, N, K);
    localparam int TW = $clog2(T + 1);

    state_t                      state;
    logic [TW-1:0]               t;
    logic [DATA_WIDTH*M*N-1:0]   x_mem;
    logic [DATA_WIDTH*N*K-1:0]   w_mem;
    logic [DATA_WIDTH*M-1:0]     x_nxt;
    logic [DATA_WIDTH*K-1:0]     w_nxt;
    logic                        wr_ok;
    int                          s;

    assign wr_ok = wr_en && state == IDLE;

    feeder_buf #(.R(M), .C(N), .DW(DATA_WIDTH), .AW(AW)) x_buf (
        .clk(clk), .rst(rst), .wr_en(wr_ok && !wr_sel), .addr(wr_addr), .data(wr_data), .mem(x_mem)
    );

    feeder_buf #(.R(N), .C(K), .DW(DATA_WIDTH), .AW(AW)) w_buf (
        .clk(clk), .rst(rst), .wr_en(wr_ok && wr_sel), .addr(wr_addr), .data(wr_data), .mem(w_mem)
    );

    // Lanes for the step about to be registered: step 0 when leaving CLEAR, else t+1
    always_comb begin
        s = state == CLEAR ? 0 : int'(t) + 1;
        x_nxt = '0;
        w_nxt = '0;
        for (int m = 0; m < M; m++)
            if (s - m >= 0 && s - m < N)
                x_nxt[DATA_WIDTH*m +: DATA_WIDTH] = x_mem[DATA_WIDTH*(m*N + s - m) +: DATA_WIDTH];
        for (int k = 0; k < K; k++)
            if (s - k >= 0 && s - k < N)
                w_nxt[DATA_WIDTH*k +: DATA_WIDTH] = w_mem[DATA_WIDTH*((s - k)*K + k) +: DATA_WIDTH];
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state      <= IDLE;
            t          <= '0;
            busy       <= 1'b0;
            arr_clr    <= 1'b0;
            feed_valid <= 1'b0;
            done       <= 1'b0;
            X_out      <= '0;
            W_out      <= '0;
        end else begin
            arr_clr <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE:
                    if (start) begin
                        state   <= CLEAR;
                        busy    <= 1'b1;
                        arr_clr <= 1'b1;
                    end
                CLEAR: begin
                    state      <= FEED;
                    t          <= '0;
                    feed_valid <= 1'b1;
                    X_out      <= x_nxt;
                    W_out      <= w_nxt;
                end
                FEED:
                    if (t == TW'(T - 1)) begin
                        state      <= FIN;
                        feed_valid <= 1'b0;
                        done       <= 1'b1;
                        X_out      <= '0;
                        W_out      <= '0;
                    end else begin
                        t     <= t + 1'b1;
                        X_out <= x_nxt;
                        W_out <= w_nxt;
                    end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: randomized scoreboard bench against a matrix-level feeder model
module tb_systolic_feeder;

    localparam int M = 5, N = 3, K = 4, DW = 32, T = 7, AW = 4;

    logic clk = 0, rst = 1, wr_en = 0, wr_sel = 0, start = 0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic busy, arr_clr, feed_valid, done;
    logic [DW*M-1:0] X_out;
    logic [DW*K-1:0] W_out;

    systolic_feeder dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .busy(busy), .arr_clr(arr_clr),
        .X_out(X_out), .W_out(W_out), .feed_valid(feed_valid), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW*M-1:0] x;
        logic [DW*K-1:0] w;
    } step_t;

    step_t exp_q[$];
    logic [DW-1:0] xm[M][N];
    logic [DW-1:0] wm[N][K];
    int tests = 0, fails = 0, cyc = 0, occ = 0, clr_cyc = -100;

    task automatic chk(string name, logic [511:0] act, logic [511:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic model_clear();
        for (int m = 0; m < M; m++) for (int n = 0; n < N; n++) xm[m][n] = '0;
        for (int n = 0; n < N; n++) for (int k = 0; k < K; k++) wm[n][k] = '0;
    endtask

    // Row m of X enters m steps late, column k of W enters k steps late
    function automatic step_t model_step(int s);
        step_t r;
        r = '0;
        for (int m = 0; m < M; m++)
            if (s >= m && s - m < N) r.x[DW*m +: DW] = xm[m][s-m];
        for (int k = 0; k < K; k++)
            if (s >= k && s - k < N) r.w[DW*k +: DW] = wm[s-k][k];
        return r;
    endfunction

    task automatic step(logic we = 0, logic sel = 0, int addr = 0, logic [DW-1:0] d = 0, logic st = 0);
        wr_en = we; wr_sel = sel; wr_addr = AW'(addr); wr_data = d; start = st;
        @(posedge clk);
        cyc++;
        if (rst) occ = 0;
        else begin
            if (we && occ == 0 && addr < (sel ? N*K : M*N)) begin
                if (sel) wm[addr/K][addr%K] = d;
                else xm[addr/N][addr%N] = d;
            end
            if (st && occ == 0) begin
                for (int s = 0; s < T; s++) exp_q.push_back(model_step(s));
                occ = T + 2;
                clr_cyc = cyc;
            end else if (occ > 0) occ--;
        end
        #1;
        wr_en = 0; start = 0;
    endtask

    always @(negedge clk) begin
        step_t e;
        if (!rst) begin
            chk("ctrl {clr,busy,fv,done}", {arr_clr, busy, feed_valid, done},
                {cyc == clr_cyc, cyc >= clr_cyc && cyc <= clr_cyc + T + 1,
                 cyc > clr_cyc && cyc <= clr_cyc + T, cyc == clr_cyc + T + 1});
            if (feed_valid) begin
                if (exp_q.size() == 0) chk("unexpected_step", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("step_lanes", {X_out, W_out}, e);
                end
            end else chk("idle_zero", {X_out, W_out}, 0);
        end
    end

    initial begin
        int ord[M*N+N*K];
        int c, j, tmp, r;
        model_clear();
        repeat (2) step();
        chk("reset_out", {busy, arr_clr, feed_valid, done, X_out, W_out}, 0);
        rst = 0;
        for (int i = 0; i < M*N+N*K; i++) ord[i] = i;
        for (int i = M*N+N*K-1; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
        end
        for (int i = 0; i < M*N+N*K; i++) begin
            if (ord[i] < M*N) step(1, 0, ord[i], DW'(10*(ord[i]/N) + ord[i]%N + 1));
            else begin
                j = ord[i] - M*N;
                step(1, 1, j, DW'(100*(j/K) + j%K + 1));
            end
        end
        step(1, 0, 15, 77);
        step(0, 0, 0, 0, 1);
        c = cyc;
        repeat (3) step();
        chk("step2_x", X_out, {32'd0, 32'd0, 32'd21, 32'd12, 32'd3});
        chk("step2_w", W_out, {32'd0, 32'd3, 32'd102, 32'd201});
        repeat (4) step();
        chk("step6_x", X_out, {32'd43, 32'd0, 32'd0, 32'd0, 32'd0});
        chk("step6_w", W_out, 0);
        chk("step6_cycle", cyc - c, 7);
        repeat (2) step();
        step(0, 0, 0, 0, 1);
        step();
        step(1, 0, 0, 999, 1);
        repeat (T) step();
        step(0, 0, 0, 0, 1);
        step();
        chk("replay_x0", X_out[DW-1:0], 1);
        repeat (T + 1) step();
        repeat (600) begin
            r = $urandom_range(0, 9);
            if (r < 4) step(1, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom);
            else if (r < 6) step(0, 0, 0, 0, 1);
            else if (r == 6) step(1, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom, 1);
            else step();
        end
        repeat (T + 3) step();
        step(0, 0, 0, 0, 1);
        repeat (4) step();
        #2 rst = 1;
        #1 chk("rst_mid_out", {busy, arr_clr, feed_valid, done, X_out, W_out}, 0);
        model_clear();
        exp_q.delete();
        clr_cyc = -100;
        step(); step();
        rst = 0;
        step(0, 0, 0, 0, 1);
        repeat (T + 3) step();
        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
